// File: rtl/predictor_update_ctrl.sv
// Update/invalidate sequencer for the branch predictor: BTB init sweep, round-robin
// enqueue of resolved branches, FIFO drain, invalidate slotting. Optional: PRED_UPD_STATS_EN.
module predictor_update_ctrl #(
  parameter int PC_BITS  = 32,
  parameter int Q_DEPTH  = 4,
  parameter int BTB_SIZE = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [PC_BITS-1:0] req0_pc,
  input  logic [PC_BITS-1:0] req0_target,
  input  logic               req0_taken,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [PC_BITS-1:0] req1_pc,
  input  logic [PC_BITS-1:0] req1_target,
  input  logic               req1_taken,
  input  logic               inv_req_valid,
  output logic               inv_req_ready,
  input  logic [PC_BITS-1:0] inv_req_pc,
  output logic               upd_valid,
  output logic [PC_BITS-1:0] upd_pc,
  output logic [PC_BITS-1:0] upd_target,
  output logic               upd_taken,
  output logic               inv_valid,
  output logic [PC_BITS-1:0] inv_pc,
`ifdef PRED_UPD_STATS_EN
  output logic               init_done,
  output logic [31:0]        stat_upd_cnt,
  output logic [31:0]        stat_stall_cnt
`else
  output logic               init_done
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(BTB_SIZE);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               inv_pending_q, inv_pending_d;
  logic               inv_valid_q, inv_valid_d;
  logic [PC_BITS-1:0] inv_pc_q, inv_pc_d;
  logic               init_done_q, init_done_d;

  logic [PC_BITS-1:0] mem_pc_q  [Q_DEPTH];
  logic [PC_BITS-1:0] mem_tgt_q [Q_DEPTH];
  logic               mem_tk_q  [Q_DEPTH];

  logic               run;
  logic               grant1;
  logic               not_full;
  logic               enq;
  logic               deq;
  logic               inv_hs;
  logic [PC_BITS-1:0] enq_pc;
  logic [PC_BITS-1:0] enq_tgt;
  logic               enq_tk;
  logic [PC_BITS-1:0] sweep_pc;

  assign run      = (state_q == ST_RUN);
  // With a single valid requester it wins regardless of rr
  assign grant1   = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign not_full = (cnt_q < CNT_W'(Q_DEPTH));

  assign req0_ready    = run & ~grant1 & not_full;
  assign req1_ready    = run &  grant1 & not_full;
  assign inv_req_ready = run & ~inv_pending_q & init_done_q;

  assign enq    = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign inv_hs = inv_req_valid & inv_req_ready;

  assign enq_pc  = grant1 ? req1_pc     : req0_pc;
  assign enq_tgt = grant1 ? req1_target : req0_target;
  assign enq_tk  = grant1 ? req1_taken  : req0_taken;

  assign upd_valid  = run & init_done_q & (cnt_q != '0) & ~inv_valid_q;
  assign deq        = upd_valid;
  assign upd_pc     = mem_pc_q[rd_ptr_q];
  assign upd_target = mem_tgt_q[rd_ptr_q];
  assign upd_taken  = mem_tk_q[rd_ptr_q];

  assign inv_valid = inv_valid_q;
  assign inv_pc    = inv_pc_q;
  assign init_done = init_done_q;

  always_comb begin
    sweep_pc = '0;
    sweep_pc[IDX_W+1:0] = {idx_q, 2'b00};
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inv_pending_d = inv_pending_q;
    inv_valid_d   = inv_valid_q;
    inv_pc_d      = inv_pc_q;
    init_done_d   = init_done_q;

    case (state_q)
      ST_INIT: begin
        inv_valid_d = 1'b1;
        inv_pc_d    = sweep_pc;
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BTB_SIZE - 1)) state_d = ST_RUN;
      end
      default: begin
        inv_valid_d   = inv_hs;
        inv_pending_d = inv_hs;
        if (inv_hs) inv_pc_d = inv_req_pc;
        init_done_d = 1'b1;
      end
    endcase

    if (enq) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rr_d     = ~grant1;
    end
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      idx_q         <= '0;
      rr_q          <= 1'b0;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inv_pending_q <= 1'b0;
      inv_valid_q   <= 1'b0;
      inv_pc_q      <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_q          <= rr_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inv_pending_q <= inv_pending_d;
      inv_valid_q   <= inv_valid_d;
      inv_pc_q      <= inv_pc_d;
      init_done_q   <= init_done_d;
    end
  end

  // Payload storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc_q[wr_ptr_q]  <= enq_pc;
      mem_tgt_q[wr_ptr_q] <= enq_tgt;
      mem_tk_q[wr_ptr_q]  <= enq_tk;
    end
  end

`ifdef PRED_UPD_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_stall_q;
  logic        stall_cyc;

  assign stall_cyc = run & (req0_valid | req1_valid) & ~(req0_ready | req1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_upd_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      if (upd_valid) stat_upd_q   <= stat_upd_q + 32'd1;
      if (stall_cyc) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_upd_cnt   = stat_upd_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule
